// File: rtl/key_expansion_seq_if.sv
// ============================================================================
// key_expansion_seq_if
//  Bundle of request, key and status signals between the AES-128 key schedule
//  and whoever drives it (controller or bench) / consumes its round keys.
//
//  Signals
//   start                     1-cycle expansion request
//   key_in                    128-bit cipher key, byte 0 = [127:120]
//   key                       registered round-0 key
//   round1_key..round10_key   expanded round keys, held until the next start
//   busy                      expansion in progress
//   keys_valid                all round keys valid and stable
//
//  Modports
//   master  drives start/key_in, observes keys and status
//   slave   the key schedule itself
// ============================================================================
interface key_expansion_seq_if;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] key;
    logic [127:0] round1_key;
    logic [127:0] round2_key;
    logic [127:0] round3_key;
    logic [127:0] round4_key;
    logic [127:0] round5_key;
    logic [127:0] round6_key;
    logic [127:0] round7_key;
    logic [127:0] round8_key;
    logic [127:0] round9_key;
    logic [127:0] round10_key;
    logic         busy;
    logic         keys_valid;

    modport master (
        output start, key_in,
        input  key,
        input  round1_key, round2_key, round3_key, round4_key, round5_key,
        input  round6_key, round7_key, round8_key, round9_key, round10_key,
        input  busy, keys_valid
    );

    modport slave (
        input  start, key_in,
        output key,
        output round1_key, round2_key, round3_key, round4_key, round5_key,
        output round6_key, round7_key, round8_key, round9_key, round10_key,
        output busy, keys_valid
    );
endinterface

// File: rtl/key_expansion_seq.sv
// ============================================================================
// key_expansion_seq
//  Sequential AES-128 key schedule. A start pulse captures key_in as the
//  round-0 key, then one round key is produced per clock until round10_key
//  is written, after which keys_valid is raised and every key is held until
//  the next accepted start.
//
//  Ports
//   clk     system clock, all state on posedge
//   reset   synchronous, active-high; clears state and every output
//   bus     key_expansion_seq_if.slave (start, key_in, key, round1..10_key,
//           busy, keys_valid)
//
//  Configuration
//   KEYEXP_ZEROIZE_EN  when defined, an accepted start also clears all round
//                      keys so stale keys from a previous expansion are never
//                      visible. Undefined (default): round keys keep their old
//                      values until rewritten.
// ============================================================================
module key_expansion_seq (
    input  logic               clk,
    input  logic               reset,
    key_expansion_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // FIPS-197 S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t       state;
    state_t       next_state;
    logic [3:0]   rnd;
    logic [127:0] prev;
    logic [127:0] key_r;
    logic [127:0] round_keys [1:10];
    logic         start_accept;
    logic         expand_step;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;
    logic [31:0]  t_word;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_round;

    // Entry b sits at bit offset (255-b)*8, and 255-b is simply ~b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // One AES-128 key-schedule round from the previous round key.
    always_comb begin
        w0     = prev[127:96];
        w1     = prev[95:64];
        w2     = prev[63:32];
        w3     = prev[31:0];
        rot_w3 = {w3[23:0], w3[31:24]};
        sub_w3 = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                  sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};
        t_word = sub_w3 ^ {rcon(rnd), 24'h0};
        n0     = w0 ^ t_word;
        n1     = w1 ^ n0;
        n2     = w2 ^ n1;
        n3     = w3 ^ n2;
        next_round = {n0, n1, n2, n3};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only honoured outside EXPAND so a request
    // while busy has no effect at all.
    always_comb begin
        next_state   = state;
        start_accept = 1'b0;
        expand_step  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    next_state   = EXPAND;
                    start_accept = 1'b1;
                end
            end
            EXPAND: begin
                expand_step = 1'b1;
                if (rnd == 4'd10) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Key datapath: capture on start, then write round<rnd>_key each step.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_r <= '0;
            prev  <= '0;
            rnd   <= '0;
            for (int i = 1; i <= 10; i++) begin
                round_keys[i] <= '0;
            end
        end else if (start_accept) begin
            key_r <= bus.key_in;
            prev  <= bus.key_in;
            rnd   <= 4'd1;
`ifdef KEYEXP_ZEROIZE_EN
            for (int i = 1; i <= 10; i++) begin
                round_keys[i] <= '0;
            end
`else
`endif
        end else if (expand_step) begin
            prev <= next_round;
            rnd  <= rnd + 4'd1;
            for (int i = 1; i <= 10; i++) begin
                if (rnd == 4'(i)) begin
                    round_keys[i] <= next_round;
                end
            end
        end
    end

    // Status flags decode the registered state only, so they can never be
    // high together and have no path from the inputs.
    assign bus.busy        = (state == EXPAND);
    assign bus.keys_valid  = (state == DONE);
    assign bus.key         = key_r;
    assign bus.round1_key  = round_keys[1];
    assign bus.round2_key  = round_keys[2];
    assign bus.round3_key  = round_keys[3];
    assign bus.round4_key  = round_keys[4];
    assign bus.round5_key  = round_keys[5];
    assign bus.round6_key  = round_keys[6];
    assign bus.round7_key  = round_keys[7];
    assign bus.round8_key  = round_keys[8];
    assign bus.round9_key  = round_keys[9];
    assign bus.round10_key = round_keys[10];

endmodule

// File: tb/tb_key_expansion_seq.sv
// ============================================================================
// tb_key_expansion_seq
//  Directed bench for key_expansion_seq using the FIPS-197 A.1 key and the
//  all-zero key: latency, hold, ignored starts, reset mid-expansion and
//  back-to-back expansion. Define KEYEXP_ZEROIZE_EN to match a zeroizing
//  build of the design.
// ============================================================================
module tb_key_expansion_seq;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_R2    = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] A1_R3    = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] A1_R4    = 128'hef44a541a8525b7fb671253bdb0bad00;
    localparam logic [127:0] A1_R5    = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    localparam logic [127:0] A1_R6    = 128'h6d88a37a110b3efddbf98641ca0093fd;
    localparam logic [127:0] A1_R7    = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    localparam logic [127:0] A1_R8    = 128'head27321b58dbad2312bf5607f8d292f;
    localparam logic [127:0] A1_R9    = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] A1_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] Z_R1     = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_R10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

`ifdef KEYEXP_ZEROIZE_EN
    localparam logic [127:0] STALE_R2  = 128'h0;
    localparam logic [127:0] STALE_R10 = 128'h0;
`else
    localparam logic [127:0] STALE_R2  = A1_R2;
    localparam logic [127:0] STALE_R10 = A1_R10;
`endif

    logic clk;
    logic reset;
    int   checkCount;
    int   passCount;
    int   failCount;

    key_expansion_seq_if bus ();

    key_expansion_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rst, input logic st, input logic [127:0] k);
        reset      = rst;
        bus.start  = st;
        bus.key_in = k;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;

        // Reset state
        applyStimulus(1'b1, 1'b0, ZERO_KEY);
        stepCycles(2);
        checkOutput("rst_busy",  128'(bus.busy), 128'd0);
        checkOutput("rst_valid", 128'(bus.keys_valid), 128'd0);
        checkOutput("rst_key",   bus.key, ZERO_KEY);
        checkOutput("rst_r1",    bus.round1_key, ZERO_KEY);
        checkOutput("rst_r10",   bus.round10_key, ZERO_KEY);
        applyStimulus(1'b0, 1'b0, ZERO_KEY);
        stepCycles(1);

        // FIPS-197 A.1 expansion with latency checks
        $display("[TB] A.1 expansion");
        applyStimulus(1'b0, 1'b1, KEY_A1);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, ZERO_KEY);
        checkOutput("a1_T_busy",  128'(bus.busy), 128'd1);
        checkOutput("a1_T_valid", 128'(bus.keys_valid), 128'd0);
        checkOutput("a1_T_key",   bus.key, KEY_A1);
        checkOutput("a1_T_r1",    bus.round1_key, ZERO_KEY);
        stepCycles(1);
        checkOutput("a1_T1_r1",   bus.round1_key, A1_R1);
        checkOutput("a1_T1_r2",   bus.round2_key, ZERO_KEY);
        stepCycles(8);
        checkOutput("a1_T9_busy",  128'(bus.busy), 128'd1);
        checkOutput("a1_T9_valid", 128'(bus.keys_valid), 128'd0);
        checkOutput("a1_T9_r9",    bus.round9_key, A1_R9);
        checkOutput("a1_T9_r10",   bus.round10_key, ZERO_KEY);
        stepCycles(1);
        checkOutput("a1_T10_busy",  128'(bus.busy), 128'd0);
        checkOutput("a1_T10_valid", 128'(bus.keys_valid), 128'd1);
        checkOutput("a1_r1",  bus.round1_key,  A1_R1);
        checkOutput("a1_r2",  bus.round2_key,  A1_R2);
        checkOutput("a1_r3",  bus.round3_key,  A1_R3);
        checkOutput("a1_r4",  bus.round4_key,  A1_R4);
        checkOutput("a1_r5",  bus.round5_key,  A1_R5);
        checkOutput("a1_r6",  bus.round6_key,  A1_R6);
        checkOutput("a1_r7",  bus.round7_key,  A1_R7);
        checkOutput("a1_r8",  bus.round8_key,  A1_R8);
        checkOutput("a1_r9",  bus.round9_key,  A1_R9);
        checkOutput("a1_r10", bus.round10_key, A1_R10);
        stepCycles(3);
        checkOutput("hold_valid", 128'(bus.keys_valid), 128'd1);
        checkOutput("hold_key",   bus.key, KEY_A1);
        checkOutput("hold_r10",   bus.round10_key, A1_R10);

        // Back-to-back: zero key started from DONE
        $display("[TB] back-to-back zero key");
        applyStimulus(1'b0, 1'b1, ZERO_KEY);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, KEY_A1);
        checkOutput("b2b_T_valid", 128'(bus.keys_valid), 128'd0);
        checkOutput("b2b_T_busy",  128'(bus.busy), 128'd1);
        checkOutput("b2b_T_key",   bus.key, ZERO_KEY);
        checkOutput("b2b_T_r10",   bus.round10_key, STALE_R10);
        stepCycles(1);
        checkOutput("b2b_T1_r1", bus.round1_key, Z_R1);
        checkOutput("b2b_T1_r2", bus.round2_key, STALE_R2);
        stepCycles(8);
        checkOutput("b2b_T9_valid", 128'(bus.keys_valid), 128'd0);
        checkOutput("b2b_T9_r10",   bus.round10_key, STALE_R10);
        stepCycles(1);
        checkOutput("b2b_T10_valid", 128'(bus.keys_valid), 128'd1);
        checkOutput("zero_r1",  bus.round1_key,  Z_R1);
        checkOutput("zero_r10", bus.round10_key, Z_R10);

        // Starts pulsed mid-expansion must be ignored
        $display("[TB] ignored starts");
        applyStimulus(1'b0, 1'b1, KEY_A1);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, ZERO_KEY);
        stepCycles(2);
        applyStimulus(1'b0, 1'b1, ZERO_KEY);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, ZERO_KEY);
        checkOutput("ign3_key",  bus.key, KEY_A1);
        checkOutput("ign3_busy", 128'(bus.busy), 128'd1);
        stepCycles(3);
        applyStimulus(1'b0, 1'b1, ZERO_KEY);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, ZERO_KEY);
        stepCycles(3);
        checkOutput("ign_valid", 128'(bus.keys_valid), 128'd1);
        checkOutput("ign_key",   bus.key, KEY_A1);
        checkOutput("ign_r5",    bus.round5_key, A1_R5);
        checkOutput("ign_r10",   bus.round10_key, A1_R10);
        stepCycles(1);
        checkOutput("ign_stay_done", 128'(bus.keys_valid), 128'd1);

        // Reset mid-expansion, with a start in the same cycle
        $display("[TB] reset mid-expansion");
        applyStimulus(1'b0, 1'b1, ZERO_KEY);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, ZERO_KEY);
        stepCycles(4);
        applyStimulus(1'b1, 1'b1, KEY_A1);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, ZERO_KEY);
        checkOutput("mrst_busy",  128'(bus.busy), 128'd0);
        checkOutput("mrst_valid", 128'(bus.keys_valid), 128'd0);
        checkOutput("mrst_key",   bus.key, ZERO_KEY);
        checkOutput("mrst_r1",    bus.round1_key, ZERO_KEY);
        checkOutput("mrst_r4",    bus.round4_key, ZERO_KEY);
        checkOutput("mrst_r10",   bus.round10_key, ZERO_KEY);
        stepCycles(1);
        checkOutput("mrst_idle_busy", 128'(bus.busy), 128'd0);
        applyStimulus(1'b0, 1'b1, KEY_A1);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, ZERO_KEY);
        stepCycles(10);
        checkOutput("post_valid", 128'(bus.keys_valid), 128'd1);
        checkOutput("post_r1",    bus.round1_key, A1_R1);
        checkOutput("post_r7",    bus.round7_key, A1_R7);
        checkOutput("post_r10",   bus.round10_key, A1_R10);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
